if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage of the five-stage RV32I pipeline. It owns the program counter and reads each 32-bit little-endian instruction over the shared byte-wide memory port, one byte per cycle. It presents `pc`, `instruction` and `prediction` to the IF_ID latch. It also redirects on EX branch resolution and follows taken predictions from the branch predictor.

## Interface
Parameters:
- `RESET_PC`, 32'h0: PC value loaded on reset.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `stall_state` in 6: stall bus. Bit[1]=1 freezes PC advance.
- `jump` in 1: EX redirect, same pulse that drives IF_ID `discard`.
- `jump_target` in 32: redirect PC.
- `pred_taken` in 1: predictor verdict for the current `pc`, combinational.
- `pred_target` in 32: predicted target for the current `pc`.
- `mem_busy` in 1: MEM stage owns the port this cycle, so no fetch issue.
- `mem_din` in 8: read data for the address issued the previous cycle.
- `mem_addr` out 32: byte address.
- `mem_rd` out 1: read strobe. Valid only when the port is not busy.
- `pc` out 32: address of the instruction being fetched or presented.
- `instruction` out 32: assembled instruction. Is 0 (bubble) unless `valid`.
- `prediction` out 1: equals `pred_taken` when `valid`, else 0.
- `stall_req` out 1: to stall controller. High while the instruction is incomplete.

## Operation
- Registers:
  - `pc`.
  - Issue count `iss` (0..4) and receive count `rcv` (0..4).
  - `pending` flag: a byte is due next cycle.
  - 32-bit byte buffer.
- `valid` = (`rcv`==4).
- Issue: when `iss`<4 and `mem_busy`=0, drive `mem_rd`=1 and `mem_addr`=`pc`+`iss`. Set `pending`<=1 and `iss`<=`iss`+1. Otherwise `mem_rd`=0 and `pending`<=0.
- Capture: if `pending`, store `mem_din` into buffer byte `rcv` (little-endian) and set `rcv`<=`rcv`+1.
- Advance: when `valid` and `stall_state[1]`=0:
  - `pc`<=`pred_taken` ? `pred_target` : `pc`+4. The add is mod 2^32, so 32'hFFFFFFFC wraps to 0.
  - Clear `iss`, `rcv`, `pending` and the buffer. Issuing of the next instruction starts the following cycle.
- Hold: when `valid` and `stall_state[1]`=1, all outputs stay constant and no memory reads are issued.
- A stall during an incomplete fetch does not pause the fetch; bytes keep arriving.
- Redirect: `jump`=1 has priority over advance, capture and issue.
  - `pc`<=`jump_target`. Clear `iss`, `rcv`, `pending` and the buffer.
  - `mem_rd` is forced to 0 that cycle.
  - A byte returning from a pre-jump request is dropped because `pending` was cleared.
- `stall_req` = !`valid`. Combinational from registers only, with no path from `stall_state`.
- `mem_addr` and `mem_rd` are combinational from registers and `mem_busy`. `mem_addr` is 0 when `mem_rd`=0.

## Timing
- Reset values:
  - `pc`=`RESET_PC`; `iss`=`rcv`=0; `pending`=0; buffer=0.
  - Outputs: `instruction`=0, `prediction`=0, `stall_req`=1, `mem_rd`=0, `mem_addr`=0.
- Assertion of `rst` mid-fetch aborts the fetch immediately. The first issue occurs on the first edge after release.
- Latency with `mem_busy`=0 throughout:
  - Cycle 0: issue byte 0.
  - Cycles 1-3: capture bytes 0-2 and issue bytes 1-3.
  - Cycle 4: capture byte 3.
  - `valid` is high from cycle 5.
  - Sustained throughput is one instruction per 6 cycles.
- Each `mem_busy` cycle during issue adds one cycle.
- When `jump` and `valid`&&!`stall_state[1]` occur together, `jump` wins.
- When `jump` occurs while `stall_state[1]`=1, the redirect is still taken.
- IF_ID samples the outputs on the same edge that advances `pc`. It therefore captures the valid instruction or the bubble.

## Structure
- Widths come from the shared `defines.v` macros:
  - `` `Instruction_Address_size `` (31:0)
  - `` `Instruction_size `` (31:0)
  - `` `Stall_size `` (5:0)
- Add to `defines.v`: `` `Byte_size `` (7:0) and `` `Fetch_bytes `` (4).
- A single flat module. Counters plus the buffer do not justify a sub-module.

## Test plan
- Reset, then memory bytes at 0..3 = 13 05 50 00 with no busy. Required:
  - `instruction`=32'h00500513 and `pc`=0 at cycle 5; `stall_req` 1 for cycles 0-4.
  - Next `mem_addr`=4.
- `mem_busy` high on cycles 1 and 2 of a fetch: `mem_rd` low on those cycles, `valid` at cycle 7, and the byte order is intact.
- `valid` with `pred_taken`=1 and `pred_target`=32'h100: `prediction`=1 and the next fetch starts at 32'h100. With `stall_state[1]`=1 for 3 cycles, the outputs are held and there are no reads.
- `jump`=1 with target 32'h40 one cycle after issuing byte 2:
  - The old byte is dropped and `pc`=32'h40.
  - The first `mem_addr`=32'h40 on the next cycle, and the instruction is assembled only from 0x40..0x43.
- `jump` coincident with advance (`pred_taken`=1): `pc` takes `jump_target`, not `pred_target`.
- `pc`=32'hFFFFFFFC, advance without prediction: next `pc`=0. Asserting `rst` asynchronously mid-fetch drops `mem_rd` at once and sets `pc` to `RESET_PC`.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: widths and constants shared by the instruction-fetch stage.
//   INSTR_ADDR_W : instruction address width
//   INSTR_W      : instruction word width
//   STALL_W      : stall bus width
//   BYTE_W       : memory port data width
//   FETCH_BYTES  : bytes per instruction
//   STALL_IF_BIT : stall bus bit that freezes the fetch stage
package if_fetch_pkg;

    localparam int INSTR_ADDR_W = 32;
    localparam int INSTR_W      = 32;
    localparam int STALL_W      = 6;
    localparam int BYTE_W       = 8;
    localparam int FETCH_BYTES  = 4;
    localparam int STALL_IF_BIT = 1;

    // Byte counters run 0..FETCH_BYTES inclusive, so they need one extra bit.
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] FETCH_CNT = 3'd4;

endpackage

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage of a five-stage RV32I pipeline.
// Owns the PC and assembles each little-endian instruction from the shared
// byte-wide memory port, one byte per cycle.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   stall_state     : stall bus; bit 1 freezes PC advance
//   jump/jump_target: EX redirect (wins over everything else)
//   pred_taken/pred_target : predictor verdict for the current pc
//   mem_busy        : MEM stage owns the port this cycle
//   mem_din         : read data for the address issued last cycle
//   mem_addr/mem_rd : byte read request (addr is 0 when rd is low)
//   pc, instruction, prediction : presented to IF_ID (bubble unless valid)
//   stall_req       : high while the instruction is incomplete
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [INSTR_ADDR_W-1:0] RESET_PC = 32'h0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_W-1:0]      stall_state,
    input  logic                    jump,
    input  logic [INSTR_ADDR_W-1:0] jump_target,
    input  logic                    pred_taken,
    input  logic [INSTR_ADDR_W-1:0] pred_target,
    input  logic                    mem_busy,
    input  logic [BYTE_W-1:0]       mem_din,
    output logic [INSTR_ADDR_W-1:0] mem_addr,
    output logic                    mem_rd,
    output logic [INSTR_ADDR_W-1:0] pc,
    output logic [INSTR_W-1:0]      instruction,
    output logic                    prediction,
    output logic                    stall_req
);

    logic [INSTR_ADDR_W-1:0] pc_reg;
    logic [CNT_W-1:0]        iss_reg;
    logic [CNT_W-1:0]        rcv_reg;
    logic                    pending_reg;
    logic [INSTR_W-1:0]      buf_reg;

    logic valid;
    logic issue;
    logic advance;
    logic flush;

    // Only the fetch-stage bit of the stall bus matters here.
    logic unused_stall;
    assign unused_stall = ^{stall_state[STALL_W-1:STALL_IF_BIT+1], stall_state[0]};

    assign valid   = (rcv_reg == FETCH_CNT);
    assign advance = valid && !stall_state[STALL_IF_BIT];
    // Either event discards the partial/complete instruction.
    assign flush   = jump || advance;

    // Gating with rst makes an asynchronous reset drop the strobe immediately,
    // not just on the next edge.
    assign issue    = !rst && !jump && !mem_busy && (iss_reg < FETCH_CNT);
    assign mem_rd   = issue;
    assign mem_addr = issue ? (pc_reg + INSTR_ADDR_W'(iss_reg)) : '0;

    assign pc          = pc_reg;
    assign instruction = valid ? buf_reg : '0;
    assign prediction  = valid && pred_taken;
    assign stall_req   = !valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg      <= RESET_PC;
            iss_reg     <= '0;
            rcv_reg     <= '0;
            pending_reg <= 1'b0;
        end else if (jump) begin
            pc_reg      <= jump_target;
            iss_reg     <= '0;
            rcv_reg     <= '0;
            pending_reg <= 1'b0;
        end else if (advance) begin
            pc_reg      <= pred_taken ? pred_target : (pc_reg + 32'd4);
            iss_reg     <= '0;
            rcv_reg     <= '0;
            pending_reg <= 1'b0;
        end else begin
            pending_reg <= issue;
            if (issue) begin
                iss_reg <= iss_reg + 3'd1;
            end
            if (pending_reg) begin
                rcv_reg <= rcv_reg + 3'd1;
            end
        end
    end

    // One register lane per byte; lane gi takes the byte that arrives when
    // the receive count points at it (little-endian assembly).
    generate
        for (genvar gi = 0; gi < FETCH_BYTES; gi++) begin : g_lane
            logic lane_we;
            assign lane_we = pending_reg && (rcv_reg[1:0] == 2'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    buf_reg[gi*BYTE_W +: BYTE_W] <= '0;
                end else if (flush) begin
                    buf_reg[gi*BYTE_W +: BYTE_W] <= '0;
                end else if (lane_we) begin
                    buf_reg[gi*BYTE_W +: BYTE_W] <= mem_din;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_state;
    logic        jump;
    logic [31:0] jump_target;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        mem_busy;
    logic [7:0]  mem_din;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        prediction;
    logic        stall_req;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
    } exp_t;

    exp_t sb[$];
    exp_t sb_e;
    logic prev_valid = 1'b0;

    if_fetch #(.RESET_PC(32'h0)) dut (
        .clk(clk),
        .rst(rst),
        .stall_state(stall_state),
        .jump(jump),
        .jump_target(jump_target),
        .pred_taken(pred_taken),
        .pred_target(pred_target),
        .mem_busy(mem_busy),
        .mem_din(mem_din),
        .mem_addr(mem_addr),
        .mem_rd(mem_rd),
        .pc(pc),
        .instruction(instruction),
        .prediction(prediction),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    // Memory contents: program at 0..3, address-derived pattern elsewhere.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [7:0] b;
        case (a)
            32'd0:   b = 8'h13;
            32'd1:   b = 8'h05;
            32'd2:   b = 8'h50;
            32'd3:   b = 8'h00;
            default: b = a[7:0] ^ 8'hA5 ^ a[31:24];
        endcase
        return b;
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    // Byte-wide memory: data returns the cycle after the request.
    always @(posedge clk) begin
        if (mem_rd) mem_din <= mem_byte(mem_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each newly presented instruction is matched against the
    // oldest expectation.
    always @(negedge clk) begin
        if (!rst && !stall_req && !prev_valid) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", 32'd1, 32'd0);
            end else begin
                sb_e = sb.pop_front();
                $display("[TB] fetch pc=%h instr=%h pred=%b (exp pc=%h instr=%h pred=%b)",
                         pc, instruction, prediction, sb_e.pc, sb_e.instr, sb_e.pred);
                check("sb_pc", pc, sb_e.pc);
                check("sb_instr", instruction, sb_e.instr);
                check("sb_pred", 32'(prediction), 32'(sb_e.pred));
            end
        end
        prev_valid <= !rst && !stall_req;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall_state = '0; jump = 1'b0; jump_target = '0;
        pred_taken = 1'b0; pred_target = '0; mem_busy = 1'b0;
        repeat (3) tick();
        check("rst_instr", instruction, 32'h0);
        check("rst_pred", 32'(prediction), 32'd0);
        check("rst_stall_req", 32'(stall_req), 32'd1);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_pc", pc, 32'h0);

        // Basic fetch from 0, cycle 0 right after release.
        rst = 1'b0;
        #1;
        check("c0_mem_rd", 32'(mem_rd), 32'd1);
        check("c0_mem_addr", mem_addr, 32'h0);
        sb.push_back('{32'h0, 32'h00500513, 1'b0});
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k <= 3) check("lat_addr", mem_addr, 32'(k));
            if (k == 4) check("c4_mem_rd", 32'(mem_rd), 32'd0);
            check("lat_stall_req", 32'(stall_req), (k < 5) ? 32'd1 : 32'd0);
        end
        check("c5_instr", instruction, 32'h00500513);
        check("c5_pc", pc, 32'h0);
        tick();
        check("next_pc", pc, 32'h4);
        check("next_addr", mem_addr, 32'h4);

        // Busy on cycles 1 and 2 of the fetch at 4.
        for (int k = 1; k <= 7; k++) begin
            tick();
            mem_busy = (k == 1 || k == 2);
            #1;
            if (k <= 2) check("busy_rd", 32'(mem_rd), 32'd0);
            if (k == 6) check("busy_stall_req6", 32'(stall_req), 32'd1);
        end
        // Cycle 7: valid; take prediction and stall.
        pred_taken = 1'b1; pred_target = 32'h100; stall_state = 6'b000010;
        sb.push_back('{32'h4, exp_instr(32'h4), 1'b1});
        #1;
        check("busy_valid7", 32'(stall_req), 32'd0);
        check("busy_instr", instruction, exp_instr(32'h4));
        check("pred_out", 32'(prediction), 32'd1);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("hold_instr", instruction, exp_instr(32'h4));
            check("hold_pc", pc, 32'h4);
            check("hold_rd", 32'(mem_rd), 32'd0);
        end
        stall_state = '0;
        tick();
        pred_taken = 1'b0;
        #1;
        check("pred_pc", pc, 32'h100);
        check("pred_addr", mem_addr, 32'h100);

        // Jump one cycle after issuing byte 2 of the fetch at 0x100.
        tick(); tick(); tick();
        jump = 1'b1; jump_target = 32'h40;
        #1;
        check("jump_rd_low", 32'(mem_rd), 32'd0);
        tick();
        jump = 1'b0;
        #1;
        check("jump_pc", pc, 32'h40);
        check("jump_addr", mem_addr, 32'h40);
        sb.push_back('{32'h40, exp_instr(32'h40), 1'b1});
        for (int k = 1; k <= 5; k++) tick();
        // Jump coincident with advance and a taken prediction.
        pred_taken = 1'b1; pred_target = 32'h100;
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        #1;
        check("jump_instr", instruction, exp_instr(32'h40));
        tick();
        jump = 1'b0; pred_taken = 1'b0;
        #1;
        check("jump_wins_pc", pc, 32'hFFFF_FFFC);
        sb.push_back('{32'hFFFF_FFFC, exp_instr(32'hFFFF_FFFC), 1'b0});
        for (int k = 1; k <= 5; k++) tick();
        check("top_instr", instruction, exp_instr(32'hFFFF_FFFC));
        tick();
        check("wrap_pc", pc, 32'h0);
        check("wrap_addr", mem_addr, 32'h0);

        // Fetch at 0 again, then reset mid-fetch at 4.
        sb.push_back('{32'h0, 32'h00500513, 1'b0});
        for (int k = 1; k <= 6; k++) tick();
        check("pc_before_rst", pc, 32'h4);
        tick(); tick();
        rst = 1'b1;
        #1;
        check("arst_rd", 32'(mem_rd), 32'd0);
        check("arst_addr", mem_addr, 32'h0);
        check("arst_pc", pc, 32'h0);
        check("arst_stall_req", 32'(stall_req), 32'd1);
        tick();
        rst = 1'b0;
        #1;
        check("rel_rd", 32'(mem_rd), 32'd1);
        sb.push_back('{32'h0, 32'h00500513, 1'b0});
        for (int k = 1; k <= 5; k++) tick();
        check("rel_instr", instruction, 32'h00500513);
        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
